// File: rtl/instr_fetch_register.sv
// instr_fetch_register
// Fetches an instruction word from memory at the PC supplied by the control
// unit and holds it in the instruction register (IR). It also decodes the
// immediate-format select for the sign-extender magic box.
//
// Optional feature: define IFR_TIMEOUT_EN to abort a READ that sees no `moc`
// for TIMEOUT_CYCLES cycles. Without it, READ waits indefinitely.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   fetch_start  fetch request, accepted only while busy=0
//   pc[31:0]     fetch address, sampled on the accept edge
//   mem_data     instruction word from memory, valid while moc=1
//   moc          memory operation complete (level)
//   mem_addr     registered read address
//   mem_rd       read strobe to memory
//   ir           instruction register (magic box IR)
//   se_sel       immediate-format select (magic box S)
//   ir_valid     ir/se_sel hold a completed fetch
//   busy         FSM not in IDLE
//   fetch_err    one-cycle pulse on misaligned pc or timeout
module instr_fetch_register #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic [31:0] pc,
  input  logic [31:0] mem_data,
  input  logic        moc,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [31:0] ir,
  output logic [1:0]  se_sel,
  output logic        ir_valid,
  output logic        busy,
  output logic        fetch_err
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 8;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0100_0000;
  localparam logic [SEL_W-1:0]  SEL_NOP  = 2'b01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state;

  // Immediate-format select from op = w[31:30] and i = w[13].
  function automatic logic [SEL_W-1:0] decode_sel(input logic [WORD_W-1:0] w);
    logic [SEL_W-1:0] sel;
    sel = 2'd3;
    unique case (w[31:30])
      2'b01:   sel = 2'd2;
      2'b00:   sel = 2'd1;
      default: sel = w[13] ? 2'd0 : 2'd3;
    endcase
    return sel;
  endfunction

`ifdef IFR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
`else
  // Timeout length only matters when the timeout feature is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0) || (CNT_W == 0);
`endif

  // Fetch FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      ir        <= NOP_WORD;
      se_sel    <= SEL_NOP;
      ir_valid  <= 1'b0;
      busy      <= 1'b0;
      fetch_err <= 1'b0;
`ifdef IFR_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      fetch_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fetch_start) begin
            ir_valid <= 1'b0;
            if (pc[1:0] == 2'b00) begin
              mem_addr <= pc;
              mem_rd   <= 1'b1;
              busy     <= 1'b1;
              state    <= READ;
`ifdef IFR_TIMEOUT_EN
              tmo_cnt  <= '0;
`endif
            end else begin
              fetch_err <= 1'b1;
            end
          end
        end
        READ: begin
          if (moc) begin
            ir       <= mem_data;
            se_sel   <= decode_sel(mem_data);
            ir_valid <= 1'b1;
            mem_rd   <= 1'b0;
            state    <= RELEASE;
`ifdef IFR_TIMEOUT_EN
          end else if (tmo_cnt == TMO_LAST) begin
            // Count reaches TIMEOUT_CYCLES on this READ cycle: abort.
            mem_rd    <= 1'b0;
            fetch_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
`endif
          end
        end
        RELEASE: begin
          // Hold off until memory drops moc so it cannot complete the next fetch.
          if (!moc) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          mem_rd <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
